// File: rtl/jogo_pkg.sv
// Shared types and codes for the battleship game sequencer and display decoder.
package jogo_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        DESLIGADO         = 3'd0,
        PREPARACAO        = 3'd1,
        PRONTO            = 3'd2,
        AGUARDA_TIRO      = 3'd3,
        AGUARDA_RESULTADO = 3'd4,
        VITORIA           = 3'd5,
        DERROTA           = 3'd6
    } estado_t;

    localparam logic [1:0] MODO_DESLIGADO  = 2'b00;
    localparam logic [1:0] MODO_PREPARACAO = 2'b01;
    localparam logic [1:0] MODO_ATAQUE     = 2'b10;

endpackage

// File: rtl/debounce_botao.sv
// Active-low button conditioner: 2-FF synchronizer, tick-sampled debouncer,
// one-cycle strobe per accepted press (high->low).
module debounce_botao #(
    parameter int AMOSTRAS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam logic [3:0] ULTIMA = 4'(AMOSTRAS - 1);

    logic       sync1_q, sync2_q;
    logic       estavel_q, estavel_d;
    logic [3:0] cnt_q, cnt_d;
    logic       press_q, press_d;

    // cnt counts consecutive samples that disagree with the accepted level
    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        if (tick_i) begin
            if (sync2_q == estavel_q) begin
                cnt_d = '0;
            end else if (cnt_q == ULTIMA) begin
                estavel_d = sync2_q;
                cnt_d     = '0;
                press_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            estavel_q <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_n_i;
            sync2_q   <= sync1_q;
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/controlador_jogo.sv
// Game sequencer: owns the phase, issues enables and fire/confirm strobes,
// counts shots and hits and declares victory, defeat or result timeout.
module controlador_jogo
    import jogo_pkg::*;
#(
    parameter int MAX_TENTATIVAS    = 12,
    parameter int TOTAL_ALVOS       = 9,
    parameter int AMOSTRAS_DEBOUNCE = 4,
    parameter int TIMEOUT_RESULTADO = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [1:0]       modo,
    input  logic             btn_confirmar_n,
    input  logic             resultado_valido,
    input  logic             resultado_acerto,
    input  logic             resultado_repetido,
    output logic             habilita_preparacao,
    output logic             habilita_ataque,
    output logic             pulso_confirma,
    output logic             disparo,
    output logic [CNT_W-1:0] tentativas,
    output logic [CNT_W-1:0] acertos,
    output logic             fim_vitoria,
    output logic             fim_derrota,
    output logic             erro_timeout,
    output logic [2:0]       estado
);

    localparam logic [CNT_W-1:0] MAX_T  = CNT_W'(MAX_TENTATIVAS);
    localparam logic [CNT_W-1:0] ALVOS  = CNT_W'(TOTAL_ALVOS);
    localparam logic [7:0]       TMO    = 8'(TIMEOUT_RESULTADO);
    localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

    logic [1:0]       modo_s1_q, modo_s2_q;
    logic             press;
    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] tent_q, tent_d, acer_q, acer_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             erro_q, erro_d;
    logic             hab_prep_q, hab_prep_d, hab_atq_q, hab_atq_d;
    logic             pulso_q, pulso_d, disp_q, disp_d;
    logic             vit_q, vit_d, der_q, der_d;
    logic             modo_off, modo_atq;

    debounce_botao #(.AMOSTRAS(AMOSTRAS_DEBOUNCE)) u_db (
        .clock   (clock),
        .reset_n (reset_n),
        .tick_i  (tick),
        .btn_n_i (btn_confirmar_n),
        .press_o (press)
    );

    assign modo_off = (modo_s2_q == MODO_DESLIGADO);
    assign modo_atq = modo_s2_q[1];

    always_comb begin
        estado_d = estado_q;
        tent_d   = tent_q;
        acer_d   = acer_q;
        tmr_d    = tmr_q;
        erro_d   = erro_q;
        pulso_d  = 1'b0;
        disp_d   = 1'b0;
        if (modo_off) begin
            estado_d = DESLIGADO;
            tent_d   = '0;
            acer_d   = '0;
            tmr_d    = '0;
            erro_d   = 1'b0;
        end else begin
            case (estado_q)
                DESLIGADO:  if (modo_s2_q == MODO_PREPARACAO) estado_d = PREPARACAO;
                PREPARACAO: if (!modo_atq && press) begin
                    pulso_d  = 1'b1;
                    estado_d = PRONTO;
                end
                PRONTO:     if (modo_atq) estado_d = AGUARDA_TIRO;
                AGUARDA_TIRO: if (press) begin
                    disp_d   = 1'b1;
                    tmr_d    = TMO;
                    estado_d = AGUARDA_RESULTADO;
                end
                // the cycle carrying disparo itself is not a result window
                AGUARDA_RESULTADO: if (!disp_q) begin
                    if (resultado_valido) begin
                        if (resultado_repetido) begin
                            estado_d = AGUARDA_TIRO;
                        end else begin
                            tent_d = tent_q + UM;
                            if (resultado_acerto) acer_d = acer_q + UM;
                            if (acer_d == ALVOS)      estado_d = VITORIA;
                            else if (tent_d == MAX_T) estado_d = DERROTA;
                            else                      estado_d = AGUARDA_TIRO;
                        end
                    end else if (tmr_q == 8'd1) begin
                        erro_d   = 1'b1;
                        estado_d = AGUARDA_TIRO;
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end
                VITORIA, DERROTA: ;
                default: estado_d = DESLIGADO;
            endcase
        end
        hab_prep_d = (estado_d == PREPARACAO) && (modo_s2_q == MODO_PREPARACAO);
        hab_atq_d  = (estado_d == AGUARDA_TIRO) || (estado_d == AGUARDA_RESULTADO);
        vit_d      = (estado_d == VITORIA);
        der_d      = (estado_d == DERROTA);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            modo_s1_q  <= MODO_DESLIGADO;
            modo_s2_q  <= MODO_DESLIGADO;
            estado_q   <= DESLIGADO;
            tent_q     <= '0;
            acer_q     <= '0;
            tmr_q      <= '0;
            erro_q     <= 1'b0;
            hab_prep_q <= 1'b0;
            hab_atq_q  <= 1'b0;
            pulso_q    <= 1'b0;
            disp_q     <= 1'b0;
            vit_q      <= 1'b0;
            der_q      <= 1'b0;
        end else begin
            modo_s1_q  <= modo;
            modo_s2_q  <= modo_s1_q;
            estado_q   <= estado_d;
            tent_q     <= tent_d;
            acer_q     <= acer_d;
            tmr_q      <= tmr_d;
            erro_q     <= erro_d;
            hab_prep_q <= hab_prep_d;
            hab_atq_q  <= hab_atq_d;
            pulso_q    <= pulso_d;
            disp_q     <= disp_d;
            vit_q      <= vit_d;
            der_q      <= der_d;
        end
    end

    assign habilita_preparacao = hab_prep_q;
    assign habilita_ataque     = hab_atq_q;
    assign pulso_confirma      = pulso_q;
    assign disparo             = disp_q;
    assign tentativas          = tent_q;
    assign acertos             = acer_q;
    assign fim_vitoria         = vit_q;
    assign fim_derrota         = der_q;
    assign erro_timeout        = erro_q;
    assign estado              = estado_q;

endmodule
